// File: rtl/rx_sample_tap_bank.sv
// rx_sample_tap_bank
// Cascaded bank of NUM_TAPS delay memories, each TAP_DEPTH samples deep.
// Every accepted sample runs a three-step transaction: it is captured, all
// banks are read at the shared pointer, and then every bank is written with
// its predecessor's read data while the read data is published on otaps.
// The result is that tap k carries the sample accepted (k+1)*TAP_DEPTH
// samples earlier. otaps_valid masks taps that the fill count shows have
// not yet been filled with real samples.
module rx_sample_tap_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 20,
    parameter int TAP_DEPTH  = 510
) (
    input  logic                           crx_clk,
    input  logic                           rrx_rst,
    input  logic                           erx_en,
    input  logic                           inew_sample_trig,
    input  logic [DATA_WIDTH-1:0]          idata_in,
    input  logic                           iflush,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] otaps,
    output logic [NUM_TAPS-1:0]            otaps_valid,
    output logic                           odata_valid,
    output logic                           osample_drop
);

    localparam int PTR_W    = (TAP_DEPTH > 1) ? $clog2(TAP_DEPTH) : 1;
    localparam int FILL_MAX = NUM_TAPS * TAP_DEPTH;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [1:0]                    rst_sync_r;
    logic                          rst_n_s;
    logic                          accept_s;
    logic                          drop_s;
    logic                          mem_re_s;
    logic                          mem_we_s;
    logic [DATA_WIDTH-1:0]         hold_r;
    logic [PTR_W-1:0]              wr_ptr_r;
    logic [FILL_W-1:0]             fill_cnt_r;
    logic [NUM_TAPS*DATA_WIDTH-1:0] otaps_r;
    logic [NUM_TAPS-1:0]           otaps_valid_r;
    logic                          odata_valid_r;
    logic                          osample_drop_r;
    logic [DATA_WIDTH-1:0]         rd_data_s [NUM_TAPS];
    logic [DATA_WIDTH-1:0]         wr_data_s [NUM_TAPS];

    // Saturating increment of the fill counter.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] cnt);
        if (cnt >= FILL_W'(FILL_MAX)) begin
            fill_inc = cnt;
        end else begin
            fill_inc = cnt + FILL_W'(1);
        end
    endfunction

    // Tap k holds a real sample once enough samples have passed to reach it.
    function automatic logic tap_filled(input logic [FILL_W-1:0] cnt, input int k);
        tap_filled = (32'(cnt) >= 32'((k + 1) * TAP_DEPTH));
    endfunction

    // Reset synchronizer: assertion is immediate, release follows two clock edges.
    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Decode accept, drop and memory strobes from the current state.
    always_comb begin
        accept_s = erx_en & inew_sample_trig & ~iflush & (state_r == ST_IDLE);
        drop_s   = erx_en & inew_sample_trig & ~iflush & (state_r != ST_IDLE);
        mem_re_s = erx_en & ~iflush & (state_r == ST_READ);
        mem_we_s = erx_en & ~iflush & (state_r == ST_WRITE);
    end

    // Next-state logic: flush aborts, a low enable freezes the sequence.
    always_comb begin
        state_nxt_s = state_r;
        if (iflush) begin
            state_nxt_s = ST_IDLE;
        end else if (!erx_en) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inew_sample_trig) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_READ:  state_nxt_s = ST_WRITE;
                ST_WRITE: state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge crx_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Delay banks: bank 0 takes the held sample, later banks chain from their predecessor.
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_r [TAP_DEPTH];
        logic [DATA_WIDTH-1:0] rd_r;

        if (gi == 0) begin : g_head
            assign wr_data_s[gi] = hold_r;
        end else begin : g_chain
            assign wr_data_s[gi] = rd_data_s[gi-1];
        end

        // Synchronous write and read at the shared pointer; contents are never reset.
        always_ff @(posedge crx_clk) begin
            if (mem_we_s) begin
                mem_r[wr_ptr_r] <= wr_data_s[gi];
            end
            if (mem_re_s) begin
                rd_r <= mem_r[wr_ptr_r];
            end
        end

        assign rd_data_s[gi] = rd_r;
    end

    // Sample capture, pointer/fill bookkeeping and registered outputs.
    always_ff @(posedge crx_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            hold_r         <= '0;
            wr_ptr_r       <= '0;
            fill_cnt_r     <= '0;
            otaps_r        <= '0;
            otaps_valid_r  <= '0;
            odata_valid_r  <= 1'b0;
            osample_drop_r <= 1'b0;
        end else if (iflush) begin
            wr_ptr_r       <= '0;
            fill_cnt_r     <= '0;
            otaps_valid_r  <= '0;
            odata_valid_r  <= 1'b0;
            osample_drop_r <= 1'b0;
        end else begin
            odata_valid_r  <= mem_we_s;
            osample_drop_r <= drop_s;
            if (accept_s) begin
                hold_r <= idata_in;
            end
            if (mem_we_s) begin
                if (wr_ptr_r == PTR_W'(TAP_DEPTH - 1)) begin
                    wr_ptr_r <= '0;
                end else begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                fill_cnt_r <= fill_inc(fill_cnt_r);
                for (int k = 0; k < NUM_TAPS; k++) begin
                    otaps_r[k*DATA_WIDTH +: DATA_WIDTH] <= rd_data_s[k];
                    otaps_valid_r[k] <= tap_filled(fill_cnt_r, k);
                end
            end
        end
    end

    assign otaps        = otaps_r;
    assign otaps_valid  = otaps_valid_r;
    assign odata_valid  = odata_valid_r;
    assign osample_drop = osample_drop_r;

endmodule
